// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the in-order pipeline (A, high priority)
// and a one-entry buffered multi-cycle result (B). A wait counter bounds how long A can starve B.
module regfile_wb_arbiter #(
   parameter int unsigned MAX_WAIT = 4,
   parameter int unsigned CNT_W    = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        a_valid,
   output logic        a_ready,
   input  logic [4:0]  a_sel,
   input  logic [31:0] a_dat,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [4:0]  b_sel,
   input  logic [31:0] b_dat,
   output logic        WEN,
   output logic [4:0]  wsel,
   output logic [31:0] wdat,
   output logic [31:0] pend_mask,
   output logic        b_drop
);

   localparam int unsigned SEL_W  = 5;
   localparam int unsigned DAT_W  = 32;
   localparam int unsigned NREG   = 32;
   localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

   logic             bbuf_valid_q, bbuf_valid_d;
   logic [SEL_W-1:0] bbuf_sel_q,   bbuf_sel_d;
   logic [DAT_W-1:0] bbuf_dat_q,   bbuf_dat_d;
   logic [CNT_W-1:0] wait_cnt_q,   wait_cnt_d;
   logic             wen_q,        wen_d;
   logic [SEL_W-1:0] wsel_q,       wsel_d;
   logic [DAT_W-1:0] wdat_q,       wdat_d;
   logic             b_drop_q,     b_drop_d;

   logic starve, a_fire, b_issue, a_kill, b_load;
   logic [NREG-1:0] mask_c;

   // Handshake and priority decisions; a_kill means A overwrites the older buffered B result.
   always_comb begin
      starve  = bbuf_valid_q && (wait_cnt_q == WAIT_MAX);
      a_ready = !starve;
      a_fire  = a_valid && a_ready;
      b_issue = bbuf_valid_q && !a_fire;
      a_kill  = a_fire && bbuf_valid_q && (a_sel == bbuf_sel_q) && (a_sel != SEL_W'(0));
      b_ready = !bbuf_valid_q || b_issue || a_kill;
      b_load  = b_valid && b_ready;
   end

   // Next-state for the B buffer, wait counter and write port.
   always_comb begin
      bbuf_valid_d = bbuf_valid_q;
      bbuf_sel_d   = bbuf_sel_q;
      bbuf_dat_d   = bbuf_dat_q;
      wait_cnt_d   = wait_cnt_q;
      wen_d        = 1'b0;
      wsel_d       = wsel_q;
      wdat_d       = wdat_q;
      b_drop_d     = a_kill;

      if (b_load) begin
         bbuf_valid_d = 1'b1;
         bbuf_sel_d   = b_sel;
         bbuf_dat_d   = b_dat;
         wait_cnt_d   = '0;
      end else if (b_issue || a_kill) begin
         bbuf_valid_d = 1'b0;
         wait_cnt_d   = '0;
      end else if (bbuf_valid_q && (wait_cnt_q != WAIT_MAX)) begin
         wait_cnt_d   = wait_cnt_q + CNT_W'(1);
      end

      if (a_fire) begin
         wen_d  = (a_sel != SEL_W'(0));
         wsel_d = a_sel;
         wdat_d = a_dat;
      end else if (b_issue) begin
         wen_d  = (bbuf_sel_q != SEL_W'(0));
         wsel_d = bbuf_sel_q;
         wdat_d = bbuf_dat_q;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         bbuf_valid_q <= 1'b0;
         bbuf_sel_q   <= '0;
         bbuf_dat_q   <= '0;
         wait_cnt_q   <= '0;
         wen_q        <= 1'b0;
         wsel_q       <= '0;
         wdat_q       <= '0;
         b_drop_q     <= 1'b0;
      end else begin
         bbuf_valid_q <= bbuf_valid_d;
         bbuf_sel_q   <= bbuf_sel_d;
         bbuf_dat_q   <= bbuf_dat_d;
         wait_cnt_q   <= wait_cnt_d;
         wen_q        <= wen_d;
         wsel_q       <= wsel_d;
         wdat_q       <= wdat_d;
         b_drop_q     <= b_drop_d;
      end
   end

   // Pending writes for hazard detection: buffered entry plus the write currently on the port.
   always_comb begin
      mask_c = '0;
      if (bbuf_valid_q) mask_c = mask_c | (NREG'(1) << bbuf_sel_q);
      if (wen_q)        mask_c = mask_c | (NREG'(1) << wsel_q);
      mask_c[0] = 1'b0;
   end

   assign pend_mask = mask_c;
   assign WEN       = wen_q;
   assign wsel      = wsel_q;
   assign wdat      = wdat_q;
   assign b_drop    = b_drop_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, lone B, starvation, WAW kill, r0, back-to-back B, async reset.
module tb_regfile_wb_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic        a_valid, b_valid;
   logic        a_ready, b_ready;
   logic [4:0]  a_sel, b_sel;
   logic [31:0] a_dat, b_dat;
   logic        WEN, b_drop;
   logic [4:0]  wsel;
   logic [31:0] wdat, pend_mask;

   int checks   = 0;
   int failures = 0;

   regfile_wb_arbiter #(.MAX_WAIT(4), .CNT_W(4)) dut (
      .CLK(CLK), .RST(RST),
      .a_valid(a_valid), .a_ready(a_ready), .a_sel(a_sel), .a_dat(a_dat),
      .b_valid(b_valid), .b_ready(b_ready), .b_sel(b_sel), .b_dat(b_dat),
      .WEN(WEN), .wsel(wsel), .wdat(wdat), .pend_mask(pend_mask), .b_drop(b_drop)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      // 1. reset with an A request waiting
      RST = 1'b1;
      a_valid = 1'b1; a_sel = 5'd3; a_dat = 32'h33;
      b_valid = 1'b0; b_sel = 5'd0; b_dat = 32'h0;
      tick(); tick();
      check("rst_wen",   32'(WEN), 32'd0);
      check("rst_pend",  pend_mask, 32'd0);
      check("rst_wsel",  32'(wsel), 32'd0);
      check("rst_drop",  32'(b_drop), 32'd0);
      RST = 1'b0;
      #1;
      check("rst_aready", 32'(a_ready), 32'd1);
      tick();
      check("rst_a_wen",  32'(WEN), 32'd1);
      check("rst_a_wsel", 32'(wsel), 32'd3);
      check("rst_a_wdat", wdat, 32'h33);
      check("rst_a_pend", pend_mask, 32'h8);

      // 2. B alone
      a_valid = 1'b0;
      b_valid = 1'b1; b_sel = 5'd7; b_dat = 32'hDEADBEEF;
      #1;
      check("b1_bready", 32'(b_ready), 32'd1);
      tick();
      b_valid = 1'b0;
      check("b1_c1_wen",  32'(WEN), 32'd0);
      check("b1_c1_pend", pend_mask, 32'h80);
      tick();
      check("b1_c2_wen",  32'(WEN), 32'd1);
      check("b1_c2_wsel", 32'(wsel), 32'd7);
      check("b1_c2_wdat", wdat, 32'hDEADBEEF);
      check("b1_c2_pend", pend_mask, 32'h80);
      tick();
      check("b1_c3_wen",  32'(WEN), 32'd0);
      check("b1_c3_pend", pend_mask, 32'h0);

      // 3. starvation: buffered sel 9 bypassed exactly MAX_WAIT times
      b_valid = 1'b1; b_sel = 5'd9; b_dat = 32'h99;
      tick();
      b_valid = 1'b0;
      a_valid = 1'b1; a_sel = 5'd4;
      for (int i = 0; i < 4; i++) begin
         a_dat = 32'h40 + 32'(i);
         #1;
         check("st_aready", 32'(a_ready), 32'd1);
         tick();
         check("st_wsel_a", 32'(wsel), 32'd4);
         check("st_wdat_a", wdat, 32'h40 + 32'(i));
         check("st_pend_a", pend_mask, 32'h210);
      end
      #1;
      check("st_stall_aready", 32'(a_ready), 32'd0);
      check("st_stall_bready", 32'(b_ready), 32'd1);
      tick();
      check("st_b_wen",  32'(WEN), 32'd1);
      check("st_b_wsel", 32'(wsel), 32'd9);
      check("st_b_wdat", wdat, 32'h99);
      check("st_b_pend", pend_mask, 32'h200);
      check("st_resume_aready", 32'(a_ready), 32'd1);
      a_dat = 32'h50;
      tick();
      check("st_resume_wsel", 32'(wsel), 32'd4);
      check("st_resume_wdat", wdat, 32'h50);

      // 4. WAW kill
      a_valid = 1'b0;
      b_valid = 1'b1; b_sel = 5'd5; b_dat = 32'h55;
      tick();
      b_valid = 1'b0;
      check("kill_pre_wen",  32'(WEN), 32'd0);
      check("kill_pre_pend", pend_mask, 32'h20);
      a_valid = 1'b1; a_sel = 5'd5; a_dat = 32'h11;
      #1;
      check("kill_bready", 32'(b_ready), 32'd1);
      check("kill_aready", 32'(a_ready), 32'd1);
      tick();
      a_valid = 1'b0;
      check("kill_wen",  32'(WEN), 32'd1);
      check("kill_wsel", 32'(wsel), 32'd5);
      check("kill_wdat", wdat, 32'h11);
      check("kill_drop", 32'(b_drop), 32'd1);
      check("kill_pend", pend_mask, 32'h20);
      tick();
      check("kill_post_wen",  32'(WEN), 32'd0);
      check("kill_post_drop", 32'(b_drop), 32'd0);
      check("kill_post_wdat", wdat, 32'h11);
      check("kill_post_pend", pend_mask, 32'h0);
      tick();
      check("kill_post2_wen", 32'(WEN), 32'd0);

      // 5. r0 writes on both ports
      a_valid = 1'b1; a_sel = 5'd0; a_dat = 32'hAA;
      b_valid = 1'b1; b_sel = 5'd0; b_dat = 32'hBB;
      #1;
      check("r0_aready", 32'(a_ready), 32'd1);
      check("r0_bready", 32'(b_ready), 32'd1);
      tick();
      a_valid = 1'b0; b_valid = 1'b0;
      check("r0_a_wen",  32'(WEN), 32'd0);
      check("r0_a_wdat", wdat, 32'hAA);
      check("r0_a_pend", pend_mask, 32'h0);
      check("r0_a_drop", 32'(b_drop), 32'd0);
      tick();
      check("r0_b_wen",  32'(WEN), 32'd0);
      check("r0_b_wdat", wdat, 32'hBB);
      check("r0_b_pend", pend_mask, 32'h0);
      check("r0_b_drop", 32'(b_drop), 32'd0);

      // 6. back-to-back B
      for (int i = 1; i <= 3; i++) begin
         b_valid = 1'b1; b_sel = 5'(i); b_dat = 32'h100 + 32'(i);
         #1;
         check("bb_bready", 32'(b_ready), 32'd1);
         tick();
         if (i > 1) begin
            check("bb_wen",  32'(WEN), 32'd1);
            check("bb_wsel", 32'(wsel), 32'(i - 1));
            check("bb_wdat", wdat, 32'h100 + 32'(i - 1));
         end
      end
      b_valid = 1'b0;
      tick();
      check("bb_last_wsel", 32'(wsel), 32'd3);
      check("bb_last_wdat", wdat, 32'h103);
      tick();
      check("bb_idle_wen", 32'(WEN), 32'd0);

      // 7. asynchronous reset mid-operation
      a_valid = 1'b1; a_sel = 5'd8; a_dat = 32'h88;
      b_valid = 1'b1; b_sel = 5'd6; b_dat = 32'h66;
      tick();
      a_valid = 1'b0; b_valid = 1'b0;
      check("ar_pre_wen",  32'(WEN), 32'd1);
      check("ar_pre_pend", pend_mask, 32'h140);
      #2;
      RST = 1'b1;
      #1;
      check("ar_wen",  32'(WEN), 32'd0);
      check("ar_wsel", 32'(wsel), 32'd0);
      check("ar_pend", pend_mask, 32'h0);
      RST = 1'b0;
      tick();
      check("ar_post_wen",  32'(WEN), 32'd0);
      check("ar_post_pend", pend_mask, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
